axi_rd_resp_mux: RTL and testbench

- Return-path counterpart of the interconnect's address decoder.
- The decoder steers each read request to one of 2**WIDTH slave channels. This block merges the read-data (R) channels of those slave channels back into the single master-side R channel.
- Each burst is granted as a whole, using round-robin arbitration, and the grant is held until the RLAST beat handshakes.
- It sits in the interconnect between the slave-channel R ports and the master R port.

---
 rtl/axi_pkg.sv | 15 +
 rtl/axi_rd_resp_mux_if.sv | 40 ++++
 rtl/axi_rd_resp_mux_rr_arbiter.sv | 29 ++
 rtl/axi_rd_resp_mux.sv | 89 ++++++++
 tb/tb_axi_rd_resp_mux.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the interconnect return paths.
// Holds RRESP encodings and the response-merger FSM states.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } rd_state_e;

endpackage

// File: rtl/axi_rd_resp_mux_if.sv
// R-channel bundle between the slave-side channels and the master port.
// The slave modport is the merger's view; master is the environment's.
interface axi_rd_resp_mux_if #(
    parameter int WIDTH      = 2,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int N = 1 << WIDTH;

    logic [N*ID_WIDTH-1:0]   SLV_RID;
    logic [N*DATA_WIDTH-1:0] SLV_RDATA;
    logic [N*2-1:0]          SLV_RRESP;
    logic [N-1:0]            SLV_RLAST;
    logic [N-1:0]            SLV_RVALID;
    logic [N-1:0]            SLV_RREADY;

    logic [ID_WIDTH-1:0]     MST_RID;
    logic [DATA_WIDTH-1:0]   MST_RDATA;
    logic [1:0]              MST_RRESP;
    logic                    MST_RLAST;
    logic                    MST_RVALID;
    logic                    MST_RREADY;

    modport slave (
        input  SLV_RID, SLV_RDATA, SLV_RRESP,
        input  SLV_RLAST, SLV_RVALID, MST_RREADY,
        output SLV_RREADY,
        output MST_RID, MST_RDATA, MST_RRESP,
        output MST_RLAST, MST_RVALID
    );

    modport master (
        output SLV_RID, SLV_RDATA, SLV_RRESP,
        output SLV_RLAST, SLV_RVALID, MST_RREADY,
        input  SLV_RREADY,
        input  MST_RID, MST_RDATA, MST_RRESP,
        input  MST_RLAST, MST_RVALID
    );

endinterface

// File: rtl/axi_rd_resp_mux_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping. Shared by the R and B response mergers.
module rr_arbiter #(
    parameter int WIDTH = 2
) (
    input  logic [(1<<WIDTH)-1:0] req,
    input  logic [WIDTH-1:0]      ptr,
    output logic [WIDTH-1:0]      gnt_idx,
    output logic                  gnt_valid
);
    localparam int N = 1 << WIDTH;

    logic [WIDTH-1:0] idx;

    // Scan from the far end so the closest candidate to ptr wins last.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + WIDTH'(k);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_resp_mux.sv
// Merges N slave-side R channels into one master R channel, granting
// whole bursts round-robin and holding the grant until RLAST handshakes.
module axi_rd_resp_mux
    import axi_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    axi_rd_resp_mux_if.slave        bus,
    output logic                    busy,
    output logic [WIDTH-1:0]        grant_sel
);
    localparam int N = 1 << WIDTH;

    rd_state_e        state_q, state_d;
    logic [WIDTH-1:0] gsel_q, gsel_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] arb_idx;
    logic             arb_vld;
    logic             g_vld;
    logic             g_last;

    rr_arbiter #(
        .WIDTH(WIDTH)
    ) u_arb (
        .req      (bus.SLV_RVALID),
        .ptr      (ptr_q),
        .gnt_idx  (arb_idx),
        .gnt_valid(arb_vld)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            gsel_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gsel_q  <= gsel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign g_vld     = bus.SLV_RVALID[gsel_q];
    assign g_last    = bus.SLV_RLAST[gsel_q];
    assign grant_sel = gsel_q;

    always_comb begin
        state_d        = state_q;
        gsel_d         = gsel_q;
        ptr_d          = ptr_q;
        busy           = 1'b0;
        bus.SLV_RREADY = '0;
        bus.MST_RVALID = 1'b0;
        bus.MST_RID    = '0;
        bus.MST_RDATA  = '0;
        bus.MST_RRESP  = '0;
        bus.MST_RLAST  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_BURST;
                    gsel_d  = arb_idx;
                end
            end
            ST_BURST: begin
                busy                   = 1'b1;
                bus.MST_RVALID         = g_vld;
                bus.SLV_RREADY[gsel_q] = bus.MST_RREADY;
                // Payload is forced to zero while no beat is offered.
                if (g_vld) begin
                    bus.MST_RID   = bus.SLV_RID[gsel_q*ID_WIDTH +: ID_WIDTH];
                    bus.MST_RDATA = bus.SLV_RDATA[gsel_q*DATA_WIDTH +: DATA_WIDTH];
                    bus.MST_RRESP = bus.SLV_RRESP[gsel_q*2 +: 2];
                    bus.MST_RLAST = g_last;
                end
                if (g_vld && bus.MST_RREADY && g_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = gsel_q + WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_resp_mux.sv
// Randomized bench for axi_rd_resp_mux against a burst-level reference
// model built from per-channel beat queues and round-robin arithmetic.
module tb_axi_rd_resp_mux;
    import axi_pkg::*;

    localparam int W  = 2;
    localparam int N  = 4;
    localparam int IW = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          busy;
    logic [W-1:0]  grant_sel;

    axi_rd_resp_mux_if #(
        .WIDTH(W), .ID_WIDTH(IW), .DATA_WIDTH(DW)
    ) bus ();

    axi_rd_resp_mux #(
        .WIDTH(W), .ID_WIDTH(IW), .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.slave),
        .busy     (busy),
        .grant_sel(grant_sel)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    beat_t  q[N][$];
    logic [N-1:0] v;
    bit     m_busy;
    bit     m_rst;
    int     m_g;
    int     m_ptr;
    bit     prev_busy;
    int     gnt_log[$];
    int     burst_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int c, input int nb, input int maxlen);
        int    len;
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            len = $urandom_range(maxlen, 1);
            for (int i = 0; i < len; i++) begin
                bt.id   = IW'($urandom);
                bt.data = {8'(c), 8'(burst_cnt), 8'(i), 8'($urandom)};
                bt.resp = 2'($urandom);
                bt.last = (i == len - 1);
                q[c].push_back(bt);
            end
            burst_cnt++;
        end
    endtask

    task automatic drive(input int vp, input int rp, input bit rst);
        logic [N*IW-1:0] rid;
        logic [N*DW-1:0] rdata;
        logic [N*2-1:0]  rresp;
        logic [N-1:0]    rlast;
        beat_t           bt;
        rstn = !rst;
        for (int c = 0; c < N; c++) begin
            v[c] = (q[c].size() > 0) && ($urandom_range(99) < vp);
            if (q[c].size() > 0) begin
                bt = q[c][0];
            end else begin
                bt.id   = IW'($urandom);
                bt.data = $urandom;
                bt.resp = 2'($urandom);
                bt.last = 1'($urandom);
            end
            rid[c*IW +: IW]   = bt.id;
            rdata[c*DW +: DW] = bt.data;
            rresp[c*2 +: 2]   = bt.resp;
            rlast[c]          = bt.last;
        end
        bus.SLV_RID    = rid;
        bus.SLV_RDATA  = rdata;
        bus.SLV_RRESP  = rresp;
        bus.SLV_RLAST  = rlast;
        bus.SLV_RVALID = v;
        bus.MST_RREADY = ($urandom_range(99) < rp);
    endtask

    // One clock: drive, compare at negedge, advance model, cross posedge.
    task automatic step(input int vp, input int rp, input bit rst);
        bit           ovld;
        bit           hs;
        bit           rel;
        beat_t        eb;
        logic [N-1:0] exp_rdy;
        int           c;
        drive(vp, rp, rst);
        @(negedge clk);
        chk("busy", busy, m_busy);
        if (m_busy)
            chk("grant_sel", grant_sel, m_g);
        else if (m_rst)
            chk("grant_sel_rst", grant_sel, 0);
        ovld = m_busy && v[m_g];
        if (ovld) eb = q[m_g][0];
        else      eb = '0;
        chk("mst_rvalid", bus.MST_RVALID, ovld);
        chk("mst_rid", bus.MST_RID, eb.id);
        chk("mst_rdata", bus.MST_RDATA, eb.data);
        chk("mst_rresp", bus.MST_RRESP, eb.resp);
        chk("mst_rlast", bus.MST_RLAST, eb.last);
        exp_rdy = '0;
        if (m_busy && bus.MST_RREADY) exp_rdy[m_g] = 1'b1;
        chk("slv_rready", bus.SLV_RREADY, exp_rdy);
        if (busy && !prev_busy) gnt_log.push_back(int'(grant_sel));
        prev_busy = busy;
        hs  = ovld && bus.MST_RREADY;
        rel = hs && eb.last;
        if (hs) void'(q[m_g].pop_front());
        if (!rstn) begin
            m_busy = 0;
            m_g    = 0;
            m_ptr  = 0;
            m_rst  = 1;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (v[c] && !m_busy) begin
                    m_busy = 1;
                    m_g    = c;
                    m_rst  = 0;
                end
            end
        end else if (rel) begin
            m_busy = 0;
            m_ptr  = (m_g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int s = 0;
        for (int c = 0; c < N; c++) s += q[c].size();
        return s;
    endfunction

    int fair_exp[6] = '{0, 1, 2, 3, 0, 1};
    int guard;
    int got_g;

    initial begin
        rstn           = 1'b0;
        bus.SLV_RID    = '0;
        bus.SLV_RDATA  = '0;
        bus.SLV_RRESP  = '0;
        bus.SLV_RLAST  = '0;
        bus.SLV_RVALID = '0;
        bus.MST_RREADY = 1'b0;
        v         = '0;
        m_busy    = 0;
        m_rst     = 1;
        m_g       = 0;
        m_ptr     = 0;
        prev_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 1);
        step(0, 0, 0);

        for (int c = 0; c < N; c++) fill(c, 2, 1);
        gnt_log.delete();
        repeat (16) step(100, 100, 0);
        for (int i = 0; i < 6; i++) begin
            got_g = (i < gnt_log.size()) ? gnt_log[i] : -1;
            chk("fair_order", got_g, fair_exp[i]);
        end

        for (int c = 0; c < N; c++) fill(c, 20, 4);
        repeat (1500) step(80, 70, $urandom_range(199) == 0);

        guard = 0;
        while (pending() > 0 && guard < 3000) begin
            step(100, 100, 0);
            guard++;
        end
        chk("drain", pending(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
